muldiv_unit: RTL
================

# muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers for the pipelined MIPS core. It sits beside the execute-stage ALU and accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the execute stage. It runs multiply and divide over WIDTH+1 cycles while asserting `busy`, which the hazard logic uses to stall any MFHI/MFLO or new mul/div. It generalises the single-cycle execute datapath with a configurable operand width, multi-cycle operation, abort and double-width results.

## Interface
- `WIDTH`, 32, operand width in bits; must be at least 4 and even.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  operation code (`muldiv_op_t`).
- `srca`  in  WIDTH  rs operand (dividend or multiplicand).
- `srcb`  in  WIDTH  rt operand (divisor or multiplier).
- `flush`  in  1  abort an operation in flight.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after HI/LO are written by a mul/div.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIXUP.
- IDLE with `start`=1:
  - MTHI writes `hi`←`srca` at that edge and MTLO writes `lo`←`srca`. Both stay in IDLE, raise no `busy` and no `done`.
  - MULT, MULTU, DIV and DIVU latch their operands, go to RUN and load the step counter with WIDTH-1.
  - Reserved op codes are ignored.
- Signed ops (MULT, DIV):
  - The unit latches operand magnitudes and records the result sign.
  - For DIV, the remainder sign follows the dividend.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring divide producing a WIDTH-bit quotient and remainder.
  - When the counter reaches 0, the next state is FIXUP.
- FIXUP:
  - Applies two's-complement sign correction.
  - Writes the results: multiply gives `hi`=upper WIDTH bits and `lo`=lower WIDTH bits; divide gives `lo`=quotient and `hi`=remainder.
  - Goes to IDLE with `done`=1 for the following cycle.
- Divide by zero (DIV and DIVU): `lo`=all ones, `hi`=`srca` (dividend). No sign fix-up is applied.
- Signed overflow, most-negative value ÷ −1: `lo`=most-negative value, `hi`=0.
- `start` while `busy`: ignored, with no queueing. The pipeline stall keeps this from happening; the bench checks it anyway.
- `flush` in RUN or FIXUP: the next state is IDLE, `hi`/`lo` are untouched and there is no `done` pulse.
- `flush` in IDLE has no effect. `flush` and `start` together in IDLE: `flush` wins and nothing is accepted.
- `flush` has priority over FIXUP's write in the same cycle.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, accumulator=0.
- Reset asserted mid-operation returns the unit to these values immediately, without waiting for a clock edge.
- Mul/div accepted at edge E0:
  - `busy`=1 from E0 through edge E0+WIDTH+1.
  - `hi`/`lo` are updated at edge E0+WIDTH+1.
  - In the cycle after that edge, `busy`=0 and `done`=1, with a total latency of WIDTH+1 cycles.
- A new `start` is accepted in the same cycle that `done` is high.
- MTHI/MTLO: the new value is visible in the cycle after the edge.
- All outputs are registered or decoded from state only, with no combinational path from inputs to outputs.

## Structure
- `muldiv_pkg` holds:
  - `muldiv_op_t`: MULT=3'd0, MULTU=3'd1, DIV=3'd2, DIVU=3'd3, MTHI=3'd4, MTLO=3'd5; 6 and 7 are reserved.
  - The state enum `muldiv_state_t`.
- Single module with no sub-module. The datapath instantiates it in the execute stage next to `alu`.

## Test plan
- WIDTH=32, MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` 33 cycles after the start edge; `busy` high for exactly 33 cycles.
- MULT −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- DIV −7 ÷ 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 0x12345678 ÷ 0 → `lo`=0xFFFFFFFF, `hi`=0x12345678.
- MTHI 0xA5A5A5A5, then start a MULTU and pulse `flush` 10 cycles later → `busy` falls on the next edge, `hi` is still 0xA5A5A5A5, no `done`.
- Second `start` issued while busy is ignored and the first result is unchanged.
- Reset pulled low mid-RUN → all outputs go to 0 without a clock edge; after release, a MULTU 6 × 7 gives `lo`=42.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared operation codes, state encoding and decode helpers for the
// iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } muldiv_state_t;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MULT) || (op == DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers,
// sitting beside the execute-stage ALU.
//
// state | meaning
// IDLE  | waiting; accepts mul/div and MTHI/MTLO
// RUN   | one shift-add or restoring-divide step per cycle
// FIXUP | sign correction and HI/LO write, then back to IDLE
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t state, state_next;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               dbz;

  logic accept_md;
  logic load_hi;
  logic load_lo;
  logic step;
  logic commit;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept_md  = 1'b0;
    load_hi    = 1'b0;
    load_lo    = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            MULT, MULTU, DIV, DIVU: begin
              accept_md  = 1'b1;
              state_next = RUN;
            end
            MTHI:    load_hi = 1'b1;
            MTLO:    load_lo = 1'b1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == '0) begin
            state_next = FIXUP;
          end
        end
      end
      FIXUP: begin
        state_next = IDLE;
        commit     = !flush;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    a_neg = is_signed_op(op) & srca[WIDTH-1];
    b_neg = is_signed_op(op) & srcb[WIDTH-1];
    a_mag = a_neg ? -srca : srca;
    b_mag = b_neg ? -srcb : srcb;
  end

  // acc holds {partial product, remaining multiplier bits} for multiply and
  // {partial remainder, remaining dividend bits / quotient} for divide.
  always_comb begin
    mul_addend = acc[0] ? opb : '0;
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc[WIDTH-1:1]};

    div_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge     = (div_shift >= {1'b0, opb});
    div_diff   = div_shift[WIDTH-1:0] - opb;
    div_next   = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ge};
  end

  // With a zero divisor the remainder path walks the dividend magnitude back
  // out, and the dividend-sign correction then restores the original srca.
  always_comb begin
    prod_fix = neg_lo ? -acc : acc;
    quot     = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      res_lo = dbz ? '1 : (neg_lo ? -quot : quot);
      res_hi = neg_hi ? -rem : rem;
    end else begin
      res_lo = prod_fix[WIDTH-1:0];
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dbz    <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= commit;
      if (accept_md) begin
        cnt    <= CW'(WIDTH - 1);
        acc    <= {{WIDTH{1'b0}}, a_mag};
        opb    <= b_mag;
        is_div <= is_div_op(op);
        neg_lo <= a_neg ^ b_neg;
        neg_hi <= a_neg;
        dbz    <= is_div_op(op) && (srcb == '0);
      end else if (step) begin
        acc <= is_div ? div_next : mul_next;
        if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end
      end
      if (load_hi) begin
        hi <= srca;
      end
      if (load_lo) begin
        lo <= srca;
      end
      if (commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule
